rotary_encoder_emulator: RTL and testbench



---
 rtl/rotary_encoder_pkg.sv | 15 +
 rtl/rotary_encoder_bounce_gen.sv | 42 ++++
 rtl/rotary_encoder_emulator.sv | 146 ++++++++++++++
 tb/tb_rotary_encoder_emulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rotary_encoder_pkg.sv
// Shared types and Gray-sequence constants for the rotary encoder emulator.
package rotary_encoder_pkg;

  typedef enum logic [1:0] {IDLE, PHASE, GAP} state_e;

  // AB pairs with A in bit 1. Entry 0 is the rest state, and one detent walks entries 1,2,3,0.
  localparam logic [1:0]      REST_AB = 2'b11;
  localparam logic [3:0][1:0] CW_SEQ  = {2'b10, 2'b00, 2'b01, 2'b11};
  localparam logic [3:0][1:0] CCW_SEQ = {2'b01, 2'b00, 2'b10, 2'b11};

  function automatic logic [1:0] seq_ab(input logic dir, input logic [1:0] idx);
    return dir ? CW_SEQ[idx] : CCW_SEQ[idx];
  endfunction

endpackage

// File: rtl/rotary_encoder_bounce_gen.sv
// Adds contact bounce to one quadrature pin: it toggles 2*bounce_pulses_p extra times after each edge.
// clean_pin and strobe are next-cycle values, so bounced_pin has the same latency as a plain pin flop.
module rotary_encoder_bounce_gen #(
  parameter int bounce_pulses_p = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean_pin,
  input  logic strobe,
  output logic bounced_pin
);

  localparam int Toggles = 2 * bounce_pulses_p;
  localparam int CntW    = (Toggles + 1 > 2) ? $clog2(Toggles + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pin_q, pin_d;

  always_comb begin
    cnt_d = cnt_q;
    pin_d = clean_pin;
    if (strobe) begin
      cnt_d = CntW'(Toggles);
    end else if (cnt_q != '0) begin
      pin_d = ~pin_q;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pin_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      pin_q <= pin_d;
    end
  end

  assign bounced_pin = pin_q;

endmodule

// File: rtl/rotary_encoder_emulator.sv
// Quadrature A/B generator driven by {direction, detent count} commands.
// Define ROTARY_ENCODER_BOUNCE_EN to add contact bounce to every pin edge.
module rotary_encoder_emulator
  import rotary_encoder_pkg::*;
#(
  parameter int phase_clk_cnt_p = 1000,
  parameter int gap_clk_cnt_p   = 4000,
  parameter int steps_width_p   = 8,
  parameter int bounce_pulses_p = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_direction,
  input  logic [steps_width_p-1:0] cmd_steps,
  output logic                     encoder_pin_a,
  output logic                     encoder_pin_b,
  output logic                     step_done,
  output logic                     busy
);

  localparam int PhW = $clog2(phase_clk_cnt_p);
  localparam int GapW = (gap_clk_cnt_p + 1 > 2) ? $clog2(gap_clk_cnt_p + 1) : 1;
  localparam logic [PhW-1:0]  PhaseLast = PhW'(phase_clk_cnt_p - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(gap_clk_cnt_p);

  state_e                   state_q, state_d;
  logic [PhW-1:0]           phase_cnt_q, phase_cnt_d;
  logic [GapW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [steps_width_p-1:0] remaining_q, remaining_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               ab_q, ab_d;
  logic                     dir_q, dir_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    ab_d        = ab_q;
    dir_d       = dir_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          dir_d       = cmd_direction;
          remaining_d = cmd_steps;
          phase_cnt_d = '0;
          gap_cnt_d   = '0;
          idx_d       = '0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (cmd_steps == '0) ? GAP : PHASE;
        end
      end
      PHASE: begin
        if (phase_cnt_q == PhaseLast) begin
          phase_cnt_d = '0;
          idx_d       = idx_q + 2'd1;
          ab_d        = seq_ab(dir_q, idx_d);
          // Index wrapping to 0 means the pins are back at rest: the detent is complete.
          if (idx_d == 2'd0) begin
            done_d      = 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == steps_width_p'(1)) begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GapLast) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      gap_cnt_q   <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      ab_q        <= REST_AB;
      dir_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      ab_q        <= ab_d;
      dir_q       <= dir_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign step_done = done_q;

`ifdef ROTARY_ENCODER_BOUNCE_EN
  rotary_encoder_bounce_gen #(.bounce_pulses_p(bounce_pulses_p)) u_bounce_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clean_pin  (ab_d[1]),
    .strobe     (ab_d[1] != ab_q[1]),
    .bounced_pin(encoder_pin_a)
  );
  rotary_encoder_bounce_gen #(.bounce_pulses_p(bounce_pulses_p)) u_bounce_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clean_pin  (ab_d[0]),
    .strobe     (ab_d[0] != ab_q[0]),
    .bounced_pin(encoder_pin_b)
  );
`else
  logic [31:0] unused_bounce_cfg;
  assign unused_bounce_cfg = 32'(bounce_pulses_p);
  assign encoder_pin_a     = ab_q[1];
  assign encoder_pin_b     = ab_q[0];
`endif

endmodule

// File: tb/tb_rotary_encoder_emulator.sv
// Directed bench for rotary_encoder_emulator with a short phase of 4 cycles and a gap of 8 cycles.
module tb_rotary_encoder_emulator;

  localparam int P = 4;
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_direction;
  logic [7:0] cmd_steps;
  logic       cmd_ready, encoder_pin_a, encoder_pin_b, step_done, busy;

  rotary_encoder_emulator #(
    .phase_clk_cnt_p(P), .gap_clk_cnt_p(G), .steps_width_p(8), .bounce_pulses_p(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_direction(cmd_direction), .cmd_steps(cmd_steps),
    .encoder_pin_a(encoder_pin_a), .encoder_pin_b(encoder_pin_b),
    .step_done(step_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Each expected record is {A, B, step_done, cmd_ready, busy}, sampled k cycles after the accept edge.
  typedef struct {
    int         k;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vec[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [1:0] ccw_t [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  function automatic logic [4:0] obs();
    return {encoder_pin_a, encoder_pin_b, step_done, cmd_ready, busy};
  endfunction

  task automatic add(input int k, input logic [1:0] ab, input logic sd, input logic rdy,
                     input logic bsy, input string name);
    vec_t v;
    v.k = k; v.exp = {ab, sd, rdy, bsy}; v.name = name;
    vec.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got AB/sd/rdy/busy=%b expected %b", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (cmd_ready !== 1'b1) chk_int("wait_ready_timeout", 0, 1);
  endtask

  // Present a command for exactly one edge; on return the current cycle is k=0.
  task automatic accept(input logic dir, input logic [7:0] steps);
    wait_ready();
    cmd_valid = 1'b1; cmd_direction = dir; cmd_steps = steps;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic play(input int lo, input int hi);
    int k = 0;
    for (int i = lo; i < hi; i++) begin
      while (k < vec[i].k) begin tick(); k++; end
      chk(vec[i].name, obs(), vec[i].exp);
    end
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6;
    int pulses, cyc;
    logic sd_seen, ab_moved;

    // Test 1: a single clockwise detent.
    t1 = vec.size();
    add(0,  2'b11, 0, 0, 1, "cw_accept");
    add(3,  2'b11, 0, 0, 1, "cw_pre_first");
    add(4,  2'b01, 0, 0, 1, "cw_t1");
    add(7,  2'b01, 0, 0, 1, "cw_t1_hold");
    add(8,  2'b00, 0, 0, 1, "cw_t2");
    add(11, 2'b00, 0, 0, 1, "cw_t2_hold");
    add(12, 2'b10, 0, 0, 1, "cw_t3");
    add(15, 2'b10, 0, 0, 1, "cw_t3_hold");
    add(16, 2'b11, 1, 0, 1, "cw_t4_done");
    add(17, 2'b11, 0, 0, 1, "cw_done_pulse_end");
    add(24, 2'b11, 0, 0, 1, "cw_gap_last");
    add(25, 2'b11, 0, 1, 0, "cw_ready_back");
    t2 = vec.size();
    // Test 2: three counter-clockwise detents.
    for (int n = 1; n <= 12; n++) begin
      add(4*n - 1, ccw_t[(n-1) % 4], 0, 0, 1, "ccw_pre");
      add(4*n,     ccw_t[n % 4], (n % 4 == 0), 0, 1, "ccw_trans");
    end
    add(56, 2'b11, 0, 0, 1, "ccw_gap_last");
    add(57, 2'b11, 0, 1, 0, "ccw_ready_back");
    t3 = vec.size();
    // Test 3: zero steps produces only the gap.
    add(0, 2'b11, 0, 0, 1, "zero_accept");
    add(4, 2'b11, 0, 0, 1, "zero_no_pin");
    add(8, 2'b11, 0, 0, 1, "zero_busy_end");
    add(9, 2'b11, 0, 1, 0, "zero_ready_back");
    t4 = vec.size();
    // Test 4: valid held high through busy; inputs change to CCW after acceptance.
    add(4,  2'b01, 0, 0, 1, "held_first_is_cw");
    add(16, 2'b11, 1, 0, 1, "held_first_done");
    add(25, 2'b11, 0, 1, 0, "held_ready_back");
    add(26, 2'b11, 0, 0, 1, "held_second_accept");
    add(29, 2'b11, 0, 0, 1, "held_second_pre");
    add(30, 2'b10, 0, 0, 1, "held_second_t1_ccw");
    add(42, 2'b11, 1, 0, 1, "held_second_done");
    add(51, 2'b11, 0, 1, 0, "held_second_ready");
    t5 = vec.size();
    // Test 5: reset in the middle of a detent.
    add(8,  2'b00, 0, 0, 1, "rst_pre_t2");
    add(10, 2'b00, 0, 0, 1, "rst_pre_hold");
    t6 = vec.size();

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_direction = 1'b0; cmd_steps = '0;
    tick(); tick();
    chk("reset_state", obs(), {2'b11, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    tick();

    accept(1'b1, 8'd1);
    play(t1, t2);

    accept(1'b0, 8'd3);
    play(t2, t3);

    accept(1'b0, 8'd0);
    play(t3, t4);

    wait_ready();
    cmd_valid = 1'b1; cmd_direction = 1'b1; cmd_steps = 8'd1;
    tick();
    cmd_direction = 1'b0; cmd_steps = 8'd1;
    play(t4, t5);
    cmd_valid = 1'b0;
    tick();
    chk("held_no_third_accept", obs(), {2'b11, 1'b0, 1'b1, 1'b0});

    accept(1'b1, 8'd1);
    play(t5, t6);
    rst_n = 1'b0;
    tick();
    chk("rst_snap", obs(), {2'b11, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    sd_seen = 1'b0; ab_moved = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      sd_seen  |= step_done;
      ab_moved |= ({encoder_pin_a, encoder_pin_b} != 2'b11);
    end
    chk("rst_quiet_after", {~ab_moved, ~ab_moved, sd_seen, cmd_ready, busy},
        {2'b11, 1'b0, 1'b1, 1'b0});

    // Maximum count: 255 detents, with no wrap back to a short command.
    accept(1'b1, 8'd255);
    pulses = 0; cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 5000) begin
      tick(); cyc++;
      if (step_done === 1'b1) pulses++;
    end
    chk_int("max_steps_pulses", pulses, 255);
    chk_int("max_steps_cycles", cyc, 255 * 4 * P + G + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
